spi_slave_ctrl: RTL and testbench

SPI responder (slave) for the bus driven by the on-chip SPI master: samples an external SPI clock, chip-select and MOSI into the system clock domain and deserialises MSB-first bytes to a local consumer. It also serialises bytes from a local producer onto MISO. It sits between the SPI pins and an accelerator-side byte interface. The bus runs in mode 3: clock idles high, MISO is driven on the falling edge, and MOSI is sampled on the rising edge.

---
 rtl/spi_pkg.sv | 28 ++
 rtl/spi_sync.sv | 34 +++
 rtl/spi_slave_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_spi_slave_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder.
//   - Mode-3 bus constants (clock idle level, sample and drive edges)
//   - FSM state encoding
//   - Default fill bit used to build FILL_BYTE
package spi_pkg;

    // Mode 3: clock idles high, drive on falling edge, sample on rising edge.
    localparam logic SPI_CLK_IDLE = 1'b1;

    typedef enum logic {
        SpiEdgeRise,
        SpiEdgeFall
    } spi_edge_e;

    localparam spi_edge_e SPI_SAMPLE_EDGE = SpiEdgeRise;
    localparam spi_edge_e SPI_DRIVE_EDGE  = SpiEdgeFall;

    // FILL_BYTE defaults to every bit set to this value.
    localparam logic SPI_FILL_BIT = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift,
        StDone
    } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// Single-bit multi-flop synchroniser.
// Ports:
//   clk_i  system clock
//   rst_i  asynchronous active-high reset (all stages load RESET_VAL)
//   d_i    asynchronous input
//   q_o    synchronised output
module spi_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI mode-3 responder. Oversamples SCLK/CS/MOSI in the clk_i domain, deserialises MSB-first
// bytes to a local consumer and serialises bytes from a local producer onto MISO.
// Optional feature macro: SPI_SLAVE_STATUS_EN (sticky overrun/underrun flags).
// Ports:
//   clk_i, rst_i                      system clock, async active-high reset
//   spi_clk_i, spi_cs_n_i, spi_mosi_i SPI pins in (asynchronous)
//   spi_miso_o, spi_miso_oe_o         SPI data out and its output enable
//   tx_data_i, tx_valid_i, tx_ready_o TX holding buffer handshake
//   rx_data_o, rx_valid_o, rx_ack_i   received byte, level valid, consumer ack
//   busy_o                            frame in progress
//   status_clr_i                      clears sticky flags
//   rx_overrun_o, tx_underrun_o       sticky status flags
module spi_slave_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] FILL_BYTE   = {DATA_W{SPI_FILL_BIT}}
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              spi_clk_i,
    input  logic              spi_cs_n_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    output logic              spi_miso_oe_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ack_i,
    output logic              busy_o,
    input  logic              status_clr_i,
    output logic              rx_overrun_o,
    output logic              tx_underrun_o
);

    localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

    logic sclk_s, cs_n_s, mosi_s;
    logic sclk_d1_q, cs_n_d1_q;
    logic sclk_rise, sclk_fall, cs_fall;

    spi_state_e        state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              miso_q, miso_d;
    logic              miso_oe_q;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              busy_q;
    logic              ovr_set, udr_set;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(SPI_CLK_IDLE)) u_sync_sclk (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (spi_clk_i),
        .q_o   (sclk_s)
    );

    // CS chain and its delayed copy reset low so that a CS held low across reset never looks
    // like a fresh falling edge; a frame starts only after CS has been seen high.
    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cs (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (spi_cs_n_i),
        .q_o   (cs_n_s)
    );

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (spi_mosi_i),
        .q_o   (mosi_s)
    );

    assign sclk_rise = sclk_s & ~sclk_d1_q;
    assign sclk_fall = ~sclk_s & sclk_d1_q;
    assign cs_fall   = ~cs_n_s & cs_n_d1_q;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        miso_d      = miso_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q & ~rx_ack_i;
        ovr_set     = 1'b0;
        udr_set     = 1'b0;

        if (tx_valid_i && !hold_full_q) begin
            hold_d      = tx_data_i;
            hold_full_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (cs_fall) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                cnt_d = '0;
                if (cs_n_s) begin
                    state_d = StIdle;
                end else begin
                    state_d = StShift;
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                    end else begin
                        // A byte offered this cycle lands in the buffer for the next LOAD.
                        shift_d = FILL_BYTE;
                        udr_set = 1'b1;
                    end
                end
            end
            StShift: begin
                if (cs_n_s) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    if (sclk_fall) begin
                        miso_d = shift_q[DATA_W-1];
                    end
                    if (sclk_rise) begin
                        shift_d = {shift_q[DATA_W-2:0], mosi_s};
                        cnt_d   = cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            state_d = StDone;
                        end
                    end
                end
            end
            StDone: begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
                ovr_set    = rx_valid_q & ~rx_ack_i;
                state_d    = cs_n_s ? StIdle : StLoad;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            cnt_q       <= '0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            sclk_d1_q   <= SPI_CLK_IDLE;
            cs_n_d1_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            miso_q      <= miso_d;
            miso_oe_q   <= (state_d != StIdle);
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            busy_q      <= (state_d != StIdle);
            sclk_d1_q   <= sclk_s;
            cs_n_d1_q   <= cs_n_s;
        end
    end

    assign spi_miso_o    = miso_q;
    assign spi_miso_oe_o = miso_oe_q;
    assign tx_ready_o    = ~hold_full_q;
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign busy_o        = busy_q;

`ifdef SPI_SLAVE_STATUS_EN
    logic ovr_q, ovr_d, udr_q, udr_d;

    always_comb begin
        ovr_d = ovr_q | ovr_set;
        udr_d = udr_q | udr_set;
        if (status_clr_i) begin
            ovr_d = 1'b0;
            udr_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovr_q <= 1'b0;
            udr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
            udr_q <= udr_d;
        end
    end

    assign rx_overrun_o  = ovr_q;
    assign tx_underrun_o = udr_q;
`else
    logic unused_status;
    assign unused_status = ^{status_clr_i, ovr_set, udr_set};

    assign rx_overrun_o  = 1'b0;
    assign tx_underrun_o = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl: a mode-3 master model with 20-cycle half periods drives
// frames; received bytes, MISO bytes and status flags are checked against hand-computed values.
// Flag expectations follow SPI_SLAVE_STATUS_EN so the same bench serves both builds.
module tb_spi_slave_ctrl;

`ifdef SPI_SLAVE_STATUS_EN
    localparam logic STAT = 1'b1;
`else
    localparam logic STAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk, cs_n, mosi;
    logic       miso, miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ack;
    logic       busy, status_clr, ovr, udr;

    logic [7:0] mtx [4];
    logic [7:0] mrx [4];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    spi_slave_ctrl u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .spi_clk_i     (sclk),
        .spi_cs_n_i    (cs_n),
        .spi_mosi_i    (mosi),
        .spi_miso_o    (miso),
        .spi_miso_oe_o (miso_oe),
        .tx_data_i     (tx_data),
        .tx_valid_i    (tx_valid),
        .tx_ready_o    (tx_ready),
        .rx_data_o     (rx_data),
        .rx_valid_o    (rx_valid),
        .rx_ack_i      (rx_ack),
        .busy_o        (busy),
        .status_clr_i  (status_clr),
        .rx_overrun_o  (ovr),
        .tx_underrun_o (udr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n clocks and leave the bench 1 ns after the last rising edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] v);
        tx_data  = v;
        tx_valid = 1'b1;
        cyc(1);
        tx_valid = 1'b0;
        cyc(1);
    endtask

    task automatic ack_rx();
        rx_ack = 1'b1;
        cyc(1);
        rx_ack = 1'b0;
        cyc(1);
    endtask

    task automatic clr_status();
        status_clr = 1'b1;
        cyc(1);
        status_clr = 1'b0;
        cyc(1);
    endtask

    // Master: nb bytes from mtx, MISO captured on each rising edge into mrx. stop_bits >= 0
    // aborts the frame after that many bits. ack_idx pulses rx_ack in the DONE cycle of that
    // byte (3 clocks after the pin edge). CS is released one clock after the final rising edge
    // so the responder sees CS high in DONE and does not reload.
    task automatic frame(input int nb, input int stop_bits, input int ack_idx);
        int nbit;
        int t;
        nbit = 0;
        cs_n = 1'b0;
        cyc(10);
        for (int b = 0; b < nb; b++) begin
            mrx[b] = 8'h00;
            for (int i = 7; i >= 0; i--) begin
                if (nbit != stop_bits) begin
                    sclk = 1'b0;
                    mosi = mtx[b][i];
                    cyc(20);
                    sclk = 1'b1;
                    mrx[b][i] = miso;
                    if (nbit == 0) begin
                        chk("busy_in_frame", 32'(busy), 32'd1);
                        chk("oe_in_frame", 32'(miso_oe), 32'd1);
                    end
                    nbit++;
                    t = 0;
                    if (b == nb - 1 && i == 0) begin
                        cyc(1);
                        cs_n = 1'b1;
                        t = 1;
                    end
                    if (b == ack_idx && i == 0) begin
                        cyc(3 - t);
                        rx_ack = 1'b1;
                        cyc(1);
                        rx_ack = 1'b0;
                        t = 4;
                    end
                    cyc(20 - t);
                end
            end
        end
        cs_n = 1'b1;
        cyc(10);
    endtask

    initial begin
        rst = 1'b1; sclk = 1'b1; cs_n = 1'b1; mosi = 1'b0;
        tx_data = 8'h00; tx_valid = 1'b0; rx_ack = 1'b0; status_clr = 1'b0;
        cyc(3);
        chk("rst_miso", 32'(miso), 32'd0);
        chk("rst_oe", 32'(miso_oe), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovr", 32'(ovr), 32'd0);
        chk("rst_udr", 32'(udr), 32'd0);
        rst = 1'b0;
        cyc(10);

        // Single byte with preloaded TX.
        preload(8'hA5);
        chk("s1_tx_ready_full", 32'(tx_ready), 32'd0);
        mtx[0] = 8'h3C;
        frame(1, -1, -1);
        chk("s1_rx_data", 32'(rx_data), 32'h3C);
        chk("s1_rx_valid", 32'(rx_valid), 32'd1);
        chk("s1_miso_byte", 32'(mrx[0]), 32'hA5);
        chk("s1_udr", 32'(udr), 32'd0);
        chk("s1_tx_ready", 32'(tx_ready), 32'd1);
        chk("s1_busy_after", 32'(busy), 32'd0);
        chk("s1_oe_after", 32'(miso_oe), 32'd0);
        ack_rx();
        chk("s1_rx_valid_acked", 32'(rx_valid), 32'd0);

        // Three bytes, nothing to send: fill bytes, underrun, and overrun from no acks.
        mtx[0] = 8'h11; mtx[1] = 8'h22; mtx[2] = 8'h33;
        frame(3, -1, -1);
        chk("s2_miso0", 32'(mrx[0]), 32'hFF);
        chk("s2_miso1", 32'(mrx[1]), 32'hFF);
        chk("s2_miso2", 32'(mrx[2]), 32'hFF);
        chk("s2_rx_data", 32'(rx_data), 32'h33);
        chk("s2_udr", 32'(udr), 32'(STAT));
        chk("s2_ovr", 32'(ovr), 32'(STAT));
        clr_status();
        chk("s2_udr_clr", 32'(udr), 32'd0);
        chk("s2_ovr_clr", 32'(ovr), 32'd0);
        ack_rx();

        // Two bytes without ack: second byte wins, overrun.
        preload(8'h96);
        mtx[0] = 8'h5A; mtx[1] = 8'hC3;
        frame(2, -1, -1);
        chk("s3_miso0", 32'(mrx[0]), 32'h96);
        chk("s3_miso1", 32'(mrx[1]), 32'hFF);
        chk("s3_rx_data", 32'(rx_data), 32'hC3);
        chk("s3_rx_valid", 32'(rx_valid), 32'd1);
        chk("s3_ovr", 32'(ovr), 32'(STAT));
        clr_status();
        ack_rx();

        // Two bytes with ack in the DONE cycle of the second: no overrun.
        mtx[0] = 8'h12; mtx[1] = 8'h34;
        frame(2, -1, 1);
        chk("s4_rx_data", 32'(rx_data), 32'h34);
        chk("s4_rx_valid", 32'(rx_valid), 32'd1);
        chk("s4_ovr", 32'(ovr), 32'd0);
        chk("s4_udr", 32'(udr), 32'(STAT));
        clr_status();
        ack_rx();

        // Abort after 5 bits, then a clean frame.
        mtx[0] = 8'hF0;
        frame(1, 5, -1);
        chk("s5_rx_valid_abort", 32'(rx_valid), 32'd0);
        chk("s5_busy_abort", 32'(busy), 32'd0);
        preload(8'hE7);
        mtx[0] = 8'h81;
        frame(1, -1, -1);
        chk("s5_rx_data", 32'(rx_data), 32'h81);
        chk("s5_rx_valid", 32'(rx_valid), 32'd1);
        chk("s5_miso_byte", 32'(mrx[0]), 32'hE7);

        // Reset mid-byte.
        cs_n = 1'b0;
        cyc(10);
        preload(8'h77);
        for (int i = 0; i < 3; i++) begin
            sclk = 1'b0; mosi = 1'b1; cyc(20);
            sclk = 1'b1; cyc(20);
        end
        sclk = 1'b0;
        cyc(20);
        rst = 1'b1;
        #2;
        chk("s6_rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("s6_rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("s6_rst_rx_data", 32'(rx_data), 32'd0);
        chk("s6_rst_busy", 32'(busy), 32'd0);
        chk("s6_rst_oe", 32'(miso_oe), 32'd0);
        chk("s6_rst_miso", 32'(miso), 32'd0);
        cyc(2);
        rst = 1'b0;
        sclk = 1'b1;
        cyc(10);
        chk("s6_no_restart", 32'(busy), 32'd0);
        cs_n = 1'b1;
        cyc(10);
        preload(8'h42);
        mtx[0] = 8'h5C;
        frame(1, -1, -1);
        chk("s6_rx_data", 32'(rx_data), 32'h5C);
        chk("s6_rx_valid", 32'(rx_valid), 32'd1);
        chk("s6_miso_byte", 32'(mrx[0]), 32'h42);
        chk("s6_udr", 32'(udr), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
